// File: rtl/mpu_store_sequencer.sv
// Walks one matrix register row-major and streams each element to memory over valid/ready.
// Latency: start at T -> probe at T+1 -> first valid at T+2; done one cycle after the last handshake.
// Backpressure: a stalled beat withholds store enable so the register file output holds the element.
// Optional size checking is enabled by defining MPU_STORE_CHECK_EN.
module mpu_store_sequencer #(
  parameter int FP              = 16,
  parameter int M               = 8,
  parameter int N               = 8,
  parameter int MBITS           = 3,
  parameter int NBITS           = 3,
  parameter int MATRIX_REG_SIZE = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_in,
  input  logic [MATRIX_REG_SIZE-1:0] start_addr_in,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       err_out,
  output logic                       reg_store_en_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr_out,
  output logic [MBITS:0]             reg_i_store_loc_out,
  output logic [NBITS:0]             reg_j_store_loc_out,
  input  logic [MBITS:0]             reg_m_store_size_in,
  input  logic [NBITS:0]             reg_n_store_size_in,
  input  logic [FP-1:0]              reg_store_element_in,
  output logic                       mem_valid_out,
  input  logic                       mem_ready_in,
  output logic [FP-1:0]              mem_data_out,
  output logic [MBITS:0]             mem_i_out,
  output logic [NBITS:0]             mem_j_out,
  output logic                       mem_last_out
);

  localparam int MW = MBITS + 1;
  localparam int NW = NBITS + 1;

  // Maximum sizes must be representable in the size/index fields.
  if (M > (2 ** MW) - 1 || N > (2 ** NW) - 1) begin : g_bad_params
    $error("mpu_store_sequencer: M/N do not fit in MBITS+1/NBITS+1 bits");
  end

  // FINISH is the done_out cycle following the last handshake.
  typedef enum logic [1:0] {IDLE, PROBE, STREAM, FINISH} state_t;

  state_t                     state_q, state_d;
  logic [MATRIX_REG_SIZE-1:0] addr_q;
  logic [MW-1:0]              i_q, i_adv, m_q, m_eff;
  logic [NW-1:0]              j_q, j_adv, n_q, n_eff;
  logic                       sized_q;
  logic                       last_loc, j_wrap, size_bad, adv;
  logic                       valid, store_en, done, err;

  // Sizes come straight from the file in the first stream cycle, then from the latched copy.
  always_comb begin
    m_eff    = sized_q ? m_q : reg_m_store_size_in;
    n_eff    = sized_q ? n_q : reg_n_store_size_in;
    last_loc = (i_q == m_eff - MW'(1)) && (j_q == n_eff - NW'(1));
    j_wrap   = (j_q == n_eff - NW'(1));
    i_adv    = j_wrap ? i_q + MW'(1) : i_q;
    j_adv    = j_wrap ? '0 : j_q + NW'(1);
`ifdef MPU_STORE_CHECK_EN
    size_bad = (m_eff == '0) || (n_eff == '0) || (m_eff > MW'(M)) || (n_eff > NW'(N));
`else
    size_bad = (m_eff == '0) || (n_eff == '0);
`endif
  end

  // Next-state and per-cycle control outputs.
  always_comb begin
    state_d  = state_q;
    valid    = 1'b0;
    store_en = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    adv      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) state_d = PROBE;
      end
      PROBE: begin
        store_en = 1'b1;
        state_d  = STREAM;
      end
      STREAM: begin
        if (size_bad) begin
          // Only reachable in the first stream cycle: nothing is emitted.
          done    = 1'b1;
`ifdef MPU_STORE_CHECK_EN
          err     = 1'b1;
`endif
          state_d = IDLE;
        end else begin
          valid = 1'b1;
          if (mem_ready_in) begin
            if (last_loc) begin
              state_d = FINISH;
            end else begin
              // Fetch the next element now so it is presented on the next cycle.
              store_en = 1'b1;
              adv      = 1'b1;
            end
          end
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched address, sizes and the location of the presented element.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      sized_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_in) begin
        addr_q  <= start_addr_in;
        i_q     <= '0;
        j_q     <= '0;
        sized_q <= 1'b0;
      end
      if (state_q == STREAM && !sized_q) begin
        m_q     <= reg_m_store_size_in;
        n_q     <= reg_n_store_size_in;
        sized_q <= 1'b1;
      end
      if (adv) begin
        i_q <= i_adv;
        j_q <= j_adv;
      end
    end
  end

  assign busy_out            = (state_q != IDLE);
  assign done_out            = done;
  assign err_out             = err;
  assign reg_store_en_out    = store_en;
  assign reg_store_addr_out  = addr_q;
  assign reg_i_store_loc_out = adv ? i_adv : i_q;
  assign reg_j_store_loc_out = adv ? j_adv : j_q;
  assign mem_valid_out       = valid;
  assign mem_data_out        = reg_store_element_in;
  assign mem_i_out           = i_q;
  assign mem_j_out           = j_q;
  assign mem_last_out        = valid && last_loc;

endmodule
